jtdd_mcu_bridge: RTL

Sits between the main 6809 and the HD63701 sub-CPU (MCU) and owns the 512-byte communication RAM.
- The main CPU requests the MCU bus through a halt handshake and accesses the shared RAM only while the bus is granted.
- It produces mcu_ram, mcu_ban and mcu_irqmain, which feed the main CPU decoder.
- It converts the main CPU's NMI-set strobe into a latched NMI towards the MCU.

---
 rtl/jtdd_com_pkg.sv | 13 +
 rtl/jtdd_com_ram.sv | 70 +++++++
 rtl/jtdd_mcu_bridge.sv | 118 +++++++++++
 3 files changed

// File: rtl/jtdd_com_pkg.sv
// rtl/jtdd_com_pkg.sv - shared types and constants for the main/MCU communication bridge
package jtdd_com_pkg;

    localparam int COM_AW = 9;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } halt_state_e;

endpackage

// File: rtl/jtdd_com_ram.sv
// rtl/jtdd_com_ram.sv - communication RAM, single-port owner mux or dual-port (JTDD_COMRAM_DUALPORT_EN)
module jtdd_com_ram
    import jtdd_com_pkg::*;
#(
    parameter int AW = COM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ban_i,
    input  logic          main_we_i,
    input  logic          main_re_i,
    input  logic [AW-1:0] main_addr_i,
    input  logic [7:0]    main_wdata_i,
    output logic [7:0]    main_rdata_o,
    input  logic          mcu_we_i,
    input  logic          mcu_re_i,
    input  logic [AW-1:0] mcu_addr_i,
    input  logic [7:0]    mcu_wdata_i,
    output logic [7:0]    mcu_rdata_o
);

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] main_rdata_q;
    logic [7:0] mcu_rdata_q;

    assign main_rdata_o = main_rdata_q;
    assign mcu_rdata_o  = mcu_rdata_q;

`ifdef JTDD_COMRAM_DUALPORT_EN
    // Main write is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (mcu_we_i)  mem[mcu_addr_i]  <= mcu_wdata_i;
        if (main_we_i) mem[main_addr_i] <= main_wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_rdata_q <= 8'h00;
            mcu_rdata_q  <= 8'h00;
        end else begin
            if (main_re_i)          main_rdata_q <= mem[main_addr_i];
            if (mcu_re_i && !ban_i) mcu_rdata_q  <= mem[mcu_addr_i];
        end
    end
`else
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          we;

    // One physical port; the bus grant decides who drives it.
    assign addr  = ban_i ? main_addr_i  : mcu_addr_i;
    assign wdata = ban_i ? main_wdata_i : mcu_wdata_i;
    assign we    = ban_i ? main_we_i    : mcu_we_i;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_rdata_q <= 8'h00;
            mcu_rdata_q  <= 8'h00;
        end else begin
            if (ban_i && main_re_i)  main_rdata_q <= mem[addr];
            if (!ban_i && mcu_re_i)  mcu_rdata_q  <= mem[addr];
        end
    end
`endif

endmodule

// File: rtl/jtdd_mcu_bridge.sv
// rtl/jtdd_mcu_bridge.sv - main 6809 / HD63701 halt handshake, comm RAM, NMI/IRQ glue (JTDD_COMRAM_DUALPORT_EN)
module jtdd_mcu_bridge
    import jtdd_com_pkg::*;
#(
    parameter int AW        = COM_AW,
    parameter int SYNC_HALT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen_main,
    input  logic          cen_mcu,
    input  logic [AW-1:0] main_AB,
    input  logic [7:0]    main_dout,
    input  logic          main_RnW,
    input  logic          com_cs,
    input  logic          mcu_halt,
    input  logic          mcu_rstb,
    input  logic          mcu_nmi_set,
    output logic [7:0]    mcu_ram,
    output logic          mcu_ban,
    output logic          mcu_irqmain,
    input  logic [AW-1:0] mcu_addr,
    input  logic [7:0]    mcu_wdata,
    input  logic          mcu_wr,
    input  logic          mcu_cs,
    output logic [7:0]    mcu_rdata,
    input  logic          mcu_irq_set,
    input  logic          mcu_nmi_clr,
    output logic          mcu_nmi,
    output logic          mcu_halted
);

    halt_state_e state_q, state_d;
    logic        halt_req;
    logic        rstb_q;
    logic        nmi_set_q, nmi_q, nmi_d;
    logic        irq_set_q, irqmain_q;

    generate
        if (SYNC_HALT != 0) begin : g_sync
            logic halt_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) halt_q <= 1'b0;
                else     halt_q <= mcu_halt;
            end
            assign halt_req = halt_q;
        end else begin : g_nosync
            assign halt_req = mcu_halt;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            rstb_q    <= 1'b1;
            nmi_set_q <= 1'b0;
            nmi_q     <= 1'b0;
            irq_set_q <= 1'b0;
            irqmain_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rstb_q    <= mcu_rstb;
            nmi_set_q <= mcu_nmi_set;
            nmi_q     <= nmi_d;
            irq_set_q <= mcu_irq_set;
            irqmain_q <= mcu_irq_set & ~irq_set_q;
        end
    end

    // MCU reset parks the bus in GRANT regardless of the clock enable.
    always_comb begin
        state_d    = state_q;
        mcu_ban    = (state_q == ST_GRANT);
        mcu_halted = (state_q != ST_RUN);
        if (!mcu_rstb) begin
            state_d = ST_GRANT;
        end else if (!rstb_q) begin
            state_d = halt_req ? ST_GRANT : ST_RELEASE;
        end else if (cen_mcu) begin
            case (state_q)
                ST_RUN:     if (halt_req) state_d = ST_DRAIN;
                ST_DRAIN: begin
                    if (!halt_req)    state_d = ST_RUN;
                    else if (!mcu_cs) state_d = ST_GRANT;
                end
                ST_GRANT:   if (!halt_req) state_d = ST_RELEASE;
                ST_RELEASE: state_d = ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        nmi_d = nmi_q;
        if (mcu_nmi_clr)                    nmi_d = 1'b0;
        else if (mcu_nmi_set && !nmi_set_q) nmi_d = 1'b1;
    end

    assign mcu_nmi     = nmi_q;
    assign mcu_irqmain = irqmain_q;

    jtdd_com_ram #(.AW(AW)) u_ram (
        .clk          (clk),
        .rst          (rst),
        .ban_i        (mcu_ban),
        .main_we_i    (com_cs & ~main_RnW & cen_main),
        .main_re_i    (com_cs),
        .main_addr_i  (main_AB),
        .main_wdata_i (main_dout),
        .main_rdata_o (mcu_ram),
        .mcu_we_i     (mcu_cs & mcu_wr & cen_mcu & ~mcu_halted),
        .mcu_re_i     (mcu_cs),
        .mcu_addr_i   (mcu_addr),
        .mcu_wdata_i  (mcu_wdata),
        .mcu_rdata_o  (mcu_rdata)
    );

endmodule
